// File: rtl/truth_table_sweeper_if.sv
// Bundle of the sweeper's stimulus, capture and readout signals.
// The slave side is the sweeper; the master side drives start, f and rd_addr.
interface truth_table_sweeper_if #(
    parameter int unsigned NFUNC = 10
);
    logic             start;
    logic             w;
    logic             x;
    logic             y;
    logic             z;
    logic [NFUNC-1:0] f;
    logic             busy;
    logic             done;
    logic [3:0]       row_idx;
    logic [15:0]      signature;
    logic [3:0]       rd_addr;
    logic [NFUNC-1:0] rd_data;

    modport master (
        output start, f, rd_addr,
        input  w, x, y, z, busy, done, row_idx, signature, rd_data
    );

    modport slave (
        input  start, f, rd_addr,
        output w, x, y, z, busy, done, row_idx, signature, rd_data
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps {w,x,y,z} through all 16 rows, samples f after a settle delay, stores each
// row in a capture memory and folds it into a rotate-XOR signature.
module truth_table_sweeper #(
    parameter int unsigned SETTLE = 4,
    parameter int unsigned NFUNC  = 10
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_sweeper_if.slave sweep_io
);
    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    localparam logic [7:0] SettleLast = 8'(SETTLE - 1);

    state_e           state_q;
    logic [7:0]       cnt_q;
    logic [3:0]       row_q;
    logic [3:0]       wxyz_q;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      sig_q;
    logic [15:0]      f_ext;
    logic [15:0]      sig_next;
    logic [NFUNC-1:0] mem_q [16];
    logic [NFUNC-1:0] rd_data_q;

    always_comb begin
        f_ext              = '0;
        f_ext[NFUNC-1:0]   = sweep_io.f;
        sig_next           = {sig_q[14:0], sig_q[15]} ^ f_ext;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            row_q     <= '0;
            wxyz_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sig_q     <= '0;
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[sweep_io.rd_addr];
            done_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (sweep_io.start) begin
                        state_q <= StSettle;
                        row_q   <= '0;
                        wxyz_q  <= '0;
                        cnt_q   <= '0;
                        sig_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StSettle: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == SettleLast) begin
                        state_q <= StSample;
                    end
                end
                StSample: begin
                    sig_q <= sig_next;
                    if (row_q == 4'hF) begin
                        // row_idx parks at 15; only a new start wraps it to 0.
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        wxyz_q  <= '0;
                    end else begin
                        state_q <= StSettle;
                        row_q   <= row_q + 4'd1;
                        wxyz_q  <= row_q + 4'd1;
                        cnt_q   <= '0;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Capture memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        assert (SETTLE >= 1 && SETTLE <= 255 && NFUNC >= 1 && NFUNC <= 16)
            else $error("truth_table_sweeper: illegal SETTLE or NFUNC");
        if (rst_n && state_q == StSample) begin
            mem_q[row_q] <= sweep_io.f;
        end
    end

    assign sweep_io.w         = wxyz_q[3];
    assign sweep_io.x         = wxyz_q[2];
    assign sweep_io.y         = wxyz_q[1];
    assign sweep_io.z         = wxyz_q[0];
    assign sweep_io.busy      = busy_q;
    assign sweep_io.done      = done_q;
    assign sweep_io.row_idx   = row_q;
    assign sweep_io.signature = sig_q;
    assign sweep_io.rd_data   = rd_data_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: loopback and constant-f sweeps, start/reset corner cases, readout.
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic rst_n;
    logic loop_a;
    logic [9:0] fconst_a;

    always #5 clk = ~clk;

    truth_table_sweeper_if #(.NFUNC(10)) if_a ();
    truth_table_sweeper_if #(.NFUNC(10)) if_b ();

    assign if_a.f = loop_a ? {6'b0, if_a.w, if_a.x, if_a.y, if_a.z} : fconst_a;
    assign if_b.f = 10'h3FF;

    truth_table_sweeper #(.SETTLE(4), .NFUNC(10)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .sweep_io (if_a.slave)
    );

    truth_table_sweeper #(.SETTLE(1), .NFUNC(10)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .sweep_io (if_b.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulses start for one edge, then watches `budget` cycles counted from the start edge.
    task automatic sweep_a(input int budget, output int done_cyc, output int n_done,
                           output logic busy1);
        @(negedge clk);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        done_cyc = 0;
        n_done   = 0;
        busy1    = if_a.busy;
        for (int k = 1; k <= budget; k++) begin
            if (k > 1) @(negedge clk);
            if (if_a.done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = k;
            end
        end
    endtask

    initial begin
        int   done_cyc;
        int   n_done;
        int   busy_late;
        logic busy1;
        logic found;

        rst_n        = 1'b0;
        loop_a       = 1'b1;
        fconst_a     = '0;
        if_a.start   = 1'b0;
        if_a.rd_addr = '0;
        if_b.start   = 1'b0;
        if_b.rd_addr = '0;
        repeat (2) @(negedge clk);

        check_eq("rst_busy", 32'(if_a.busy), 32'd0);
        check_eq("rst_done", 32'(if_a.done), 32'd0);
        check_eq("rst_row", 32'(if_a.row_idx), 32'd0);
        check_eq("rst_wxyz", 32'({if_a.w, if_a.x, if_a.y, if_a.z}), 32'd0);
        check_eq("rst_sig", 32'(if_a.signature), 32'd0);
        check_eq("rst_rd_data", 32'(if_a.rd_data), 32'd0);
        rst_n = 1'b1;

        // Loopback sweep, SETTLE = 4.
        sweep_a(90, done_cyc, n_done, busy1);
        check_eq("loop_busy_c1", 32'(busy1), 32'd1);
        check_eq("loop_done_cyc", 32'(done_cyc), 32'd81);
        check_eq("loop_done_cnt", 32'(n_done), 32'd1);
        check_eq("loop_sig", 32'(if_a.signature), 32'h08F7);
        check_eq("loop_idle_busy", 32'(if_a.busy), 32'd0);
        for (int n = 0; n < 16; n++) begin
            if_a.rd_addr = 4'(n);
            @(negedge clk);
            check_eq($sformatf("loop_rd[%0d]", n), 32'(if_a.rd_data), 32'(n));
        end

        // Constant f = 3FF, SETTLE = 1: each row held two cycles.
        @(negedge clk);
        if_b.start = 1'b1;
        @(negedge clk);
        if_b.start = 1'b0;
        done_cyc = 0;
        n_done   = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= 33)
                check_eq($sformatf("b_wxyz_c%0d", k), 32'({if_b.w, if_b.x, if_b.y, if_b.z}),
                         (k == 33) ? 32'd0 : 32'((k - 1) / 2));
            if (if_b.done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = k;
            end
        end
        check_eq("b_done_cyc", 32'(done_cyc), 32'd33);
        check_eq("b_done_cnt", 32'(n_done), 32'd1);
        for (int n = 0; n < 16; n++) begin
            if_b.rd_addr = 4'(n);
            @(negedge clk);
            check_eq($sformatf("b_rd[%0d]", n), 32'(if_b.rd_data), 32'h3FF);
        end

        // start held through the sweep and the DONE cycle: still one sweep.
        @(negedge clk);
        if_a.start = 1'b1;
        done_cyc  = 0;
        n_done    = 0;
        busy_late = 0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (if_a.done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (k >= 82 && if_a.busy) busy_late++;
            if (k == 81) if_a.start = 1'b0;
        end
        check_eq("hold_done_cyc", 32'(done_cyc), 32'd81);
        check_eq("hold_done_cnt", 32'(n_done), 32'd1);
        check_eq("hold_busy_after", 32'(busy_late), 32'd0);
        check_eq("hold_row_parked", 32'(if_a.row_idx), 32'd15);

        // Reset at row 7 aborts the sweep without a done pulse.
        @(negedge clk);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (if_a.row_idx == 4'd7) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("abort_reach_row7", 32'(found), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 32'(if_a.busy), 32'd0);
        check_eq("abort_row", 32'(if_a.row_idx), 32'd0);
        check_eq("abort_wxyz", 32'({if_a.w, if_a.x, if_a.y, if_a.z}), 32'd0);
        check_eq("abort_sig", 32'(if_a.signature), 32'd0);
        check_eq("abort_done", 32'(if_a.done), 32'd0);
        rst_n  = 1'b1;
        n_done = 0;
        repeat (100) begin
            @(negedge clk);
            if (if_a.done) n_done++;
        end
        check_eq("abort_no_done", 32'(n_done), 32'd0);

        sweep_a(90, done_cyc, n_done, busy1);
        check_eq("fresh_done_cyc", 32'(done_cyc), 32'd81);
        check_eq("fresh_sig", 32'(if_a.signature), 32'h08F7);
        repeat (5) @(negedge clk);
        check_eq("sig_held", 32'(if_a.signature), 32'h08F7);

        // Back-to-back sweep with f = 0: signature cleared on start.
        loop_a   = 1'b0;
        fconst_a = 10'h000;
        sweep_a(90, done_cyc, n_done, busy1);
        check_eq("zero_done_cyc", 32'(done_cyc), 32'd81);
        check_eq("zero_sig", 32'(if_a.signature), 32'h0000);

        // Poll row 3 during a loopback sweep: old value until cycle 22.
        loop_a       = 1'b1;
        if_a.rd_addr = 4'd3;
        @(negedge clk);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) @(negedge clk);
            if (k >= 18)
                check_eq($sformatf("poll_rd3_c%0d", k), 32'(if_a.rd_data),
                         (k >= 22) ? 32'd3 : 32'd0);
        end
        found = 1'b0;
        for (int k = 31; k <= 100 && !found; k++) begin
            @(negedge clk);
            if (if_a.done) found = 1'b1;
        end
        check_eq("poll_done_seen", 32'(found), 32'd1);
        check_eq("poll_sig", 32'(if_a.signature), 32'h08F7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
